// File: rtl/fault_event_queue_pkg.sv
// fault_event_queue_pkg: shared encodings for the fault display queue.
// Fault types, FSM states, queue entry layout and legality check.
package fault_event_queue_pkg;

  localparam logic [1:0] FT_NONE   = 2'd0;
  localparam logic [1:0] FT_IFAULT = 2'd1;
  localparam logic [1:0] FT_PBLOCK = 2'd2;
  localparam logic [1:0] FT_BDROP  = 2'd3;

  localparam logic [1:0] MAX_UNIT = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    GAP
  } state_t;

  typedef struct packed {
    logic [1:0] unit;
    logic [1:0] ftype;
  } fault_ev_t;

  function automatic logic ev_legal(
    input logic [1:0] unit,
    input logic [1:0] ftype
  );
    return (unit <= MAX_UNIT) &&
           (ftype != FT_NONE);
  endfunction

endpackage

// File: rtl/fault_event_queue_if.sv
// fault_event_queue_if: report handshake and LED-stage outputs.
// master = report source / observer, slave = fault_event_queue.
interface fault_event_queue_if #(
  parameter int DEPTH = 4
);
  logic                     ev_valid;
  logic [1:0]               ev_unit;
  logic [1:0]               ev_type;
  logic                     ev_ready;
  logic                     resolve;
  logic [1:0]               unitlist;
  logic                     i_fault;
  logic                     p_block;
  logic                     b_drop;
  logic                     busy;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;
  logic                     bad_event;

  modport master (
    output ev_valid, ev_unit, ev_type,
    output resolve,
    input  ev_ready, unitlist,
    input  i_fault, p_block, b_drop,
    input  busy, count,
    input  overflow, bad_event
  );

  modport slave (
    input  ev_valid, ev_unit, ev_type,
    input  resolve,
    output ev_ready, unitlist,
    output i_fault, p_block, b_drop,
    output busy, count,
    output overflow, bad_event
  );
endinterface

// File: rtl/fault_event_queue_fifo.sv
// fault_fifo: synchronous FIFO of {unit, type} fault entries.
// push/pop/wdata in; rdata (head), count, count_d (next), full, empty out.
module fault_fifo
  import fault_event_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  fault_ev_t              wdata,
  input  logic                   pop,
  output fault_ev_t              rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic [$clog2(DEPTH):0] count_d,
  output logic                   full,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fault_ev_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];
  assign count_d = count
                 + CW'(do_push)
                 - CW'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Power-of-two depth: pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_d;
      full  <= (count_d == FULL_CNT);
      empty <= (count_d == '0);
    end
  end
endmodule

// File: rtl/fault_event_queue.sv
// fault_event_queue: queues fault reports and shows each on the LED stage.
// clk_50M/reset plain; bus carries reports, resolve and LED/status outputs.
module fault_event_queue
  import fault_event_queue_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int GAP_CYCLES  = 5_000_000
) (
  input  logic          clk_50M,
  input  logic          reset,
  fault_event_queue_if.slave bus
);
  localparam int CW   = $clog2(DEPTH) + 1;
  localparam int TMAX = (HOLD_CYCLES > GAP_CYCLES)
                      ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LD  = TW'(GAP_CYCLES - 1);

  state_t          state;
  logic [TW-1:0]   timer;
  logic [1:0]      unit_q;
  logic            i_q;
  logic            p_q;
  logic            b_q;
  logic            busy_q;
  logic            ovf_q;
  logic            bad_q;

  fault_ev_t       head;
  fault_ev_t       wdata;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_d;
  logic            full;
  logic            empty;
  logic            legal;
  logic            push;
  logic            pop;
  logic            to_idle;

  assign legal = ev_legal(bus.ev_unit, bus.ev_type);
  assign push  = bus.ev_valid & ~full & legal;
  assign pop   = (state == IDLE) & ~empty;
  assign wdata = '{unit: bus.ev_unit, ftype: bus.ev_type};

  // Next cycle ends up idle: used to register busy.
  assign to_idle = ((state == IDLE) & empty) |
                   ((state == GAP) & (timer == '0));

  fault_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk_50M),
    .rst     (reset),
    .push    (push),
    .wdata   (wdata),
    .pop     (pop),
    .rdata   (head),
    .count   (count),
    .count_d (count_d),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      timer  <= '0;
      unit_q <= '0;
      i_q    <= 1'b0;
      p_q    <= 1'b0;
      b_q    <= 1'b0;
      busy_q <= 1'b0;
      ovf_q  <= 1'b0;
      bad_q  <= 1'b0;
    end else begin
      if (bus.ev_valid & full)   ovf_q <= 1'b1;
      if (bus.ev_valid & ~legal) bad_q <= 1'b1;
      busy_q <= ~(to_idle & (count_d == '0));
      unique case (state)
        IDLE: begin
          if (!empty) begin
            unit_q <= head.unit;
            i_q    <= (head.ftype == FT_IFAULT);
            p_q    <= (head.ftype == FT_PBLOCK);
            b_q    <= (head.ftype == FT_BDROP);
            timer  <= HOLD_LD;
            state  <= SHOW;
          end
        end
        SHOW: begin
          if ((timer == '0) || bus.resolve) begin
            i_q   <= 1'b0;
            p_q   <= 1'b0;
            b_q   <= 1'b0;
            timer <= GAP_LD;
            state <= GAP;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        GAP: begin
          if (timer == '0) state <= IDLE;
          else             timer <= timer - TW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ev_ready  = ~full;
  assign bus.unitlist  = unit_q;
  assign bus.i_fault   = i_q;
  assign bus.p_block   = p_q;
  assign bus.b_drop    = b_q;
  assign bus.busy      = busy_q;
  assign bus.count     = count;
  assign bus.overflow  = ovf_q;
  assign bus.bad_event = bad_q;
endmodule

// File: tb/tb_fault_event_queue.sv
// tb_fault_event_queue: directed bench with display-order scoreboard.
// Small timing parameters: HOLD=8, GAP=3, DEPTH=4.
module tb_fault_event_queue;
  localparam int DEPTH = 4;
  localparam int HOLD  = 8;
  localparam int GAP   = 3;

  logic clk_50M = 1'b0;
  logic reset   = 1'b1;

  always #10 clk_50M = ~clk_50M;

  fault_event_queue_if #(.DEPTH(DEPTH)) bus();

  fault_event_queue #(
    .DEPTH       (DEPTH),
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk_50M (clk_50M),
    .reset   (reset),
    .bus     (bus)
  );

  int tests = 0;
  int fails = 0;
  logic [3:0] exp_q [$];
  logic [2:0] prev_f = 3'b000;
  logic [2:0] mon_f;
  logic [3:0] mon_e;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic ev(input logic [1:0] u,
                    input logic [1:0] t,
                    input bit acc);
    bus.ev_valid = 1'b1;
    bus.ev_unit  = u;
    bus.ev_type  = t;
    if (acc) exp_q.push_back({u, t});
    tick();
    bus.ev_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (bus.busy !== 1'b0 && n < max) begin
      tick();
      n++;
    end
    check("idle_in_time", bus.busy, 0);
  endtask

  function automatic logic [1:0] ftype_of(
    input logic [2:0] f
  );
    case (f)
      3'b100:  return 2'd1;
      3'b010:  return 2'd2;
      3'b001:  return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [2:0] flags();
    return {bus.i_fault, bus.p_block, bus.b_drop};
  endfunction

  // Scoreboard: each new display must match the oldest accepted report.
  always @(negedge clk_50M) begin
    mon_f = flags();
    if (!reset) begin
      check("onehot", $countones(mon_f) <= 1, 1);
      if (mon_f != 3'b000 && prev_f == 3'b000) begin
        check("display_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("display_order",
                {bus.unitlist, ftype_of(mon_f)}, mon_e);
        end
      end
    end
    prev_f = mon_f;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ev_valid = 1'b0;
    bus.ev_unit  = 2'd0;
    bus.ev_type  = 2'd0;
    bus.resolve  = 1'b0;
    repeat (2) tick();
    check("rst_flags", flags(), 0);
    check("rst_unit", bus.unitlist, 0);
    check("rst_count", bus.count, 0);
    check("rst_ovf", bus.overflow, 0);
    check("rst_bad", bus.bad_event, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_ready", bus.ev_ready, 1);
    reset = 1'b0;
    tick();

    // 1: single report, hold and gap timing
    ev(2'd1, 2'd2, 1'b1);
    check("t1_count", bus.count, 1);
    check("t1_busy", bus.busy, 1);
    check("t1_not_yet", bus.p_block, 0);
    tick();
    check("t1_pblock", bus.p_block, 1);
    check("t1_unit", bus.unitlist, 1);
    check("t1_popped", bus.count, 0);
    repeat (HOLD - 1) tick();
    check("t1_hold_last", bus.p_block, 1);
    tick();
    check("t1_hold_end", bus.p_block, 0);
    check("t1_unit_kept", bus.unitlist, 1);
    repeat (GAP - 1) tick();
    check("t1_gap_busy", bus.busy, 1);
    tick();
    check("t1_idle", bus.busy, 0);

    // 2: fill the queue while the first is shown
    ev(2'd0, 2'd1, 1'b1);
    ev(2'd1, 2'd1, 1'b1);
    ev(2'd2, 2'd2, 1'b1);
    ev(2'd0, 2'd3, 1'b1);
    ev(2'd1, 2'd3, 1'b1);
    check("t2_full_count", bus.count, 4);
    check("t2_not_ready", bus.ev_ready, 0);
    check("t2_no_ovf_yet", bus.overflow, 0);
    ev(2'd2, 2'd1, 1'b0);
    check("t2_ovf", bus.overflow, 1);
    check("t2_count_kept", bus.count, 4);
    wait_idle(100);
    check("t2_drained", exp_q.size(), 0);

    // 3: resolve in SHOW, ignored in GAP
    ev(2'd2, 2'd3, 1'b1);
    ev(2'd1, 2'd1, 1'b1);
    check("t3_bdrop", bus.b_drop, 1);
    check("t3_unit", bus.unitlist, 2);
    repeat (2) tick();
    bus.resolve = 1'b1;
    tick();
    bus.resolve = 1'b0;
    check("t3_resolved", flags(), 0);
    check("t3_unit_kept", bus.unitlist, 2);
    bus.resolve = 1'b1;
    tick();
    bus.resolve = 1'b0;
    check("t3_gap1", flags(), 0);
    tick();
    check("t3_gap2", flags(), 0);
    tick();
    check("t3_gap3", flags(), 0);
    tick();
    check("t3_next_on", bus.i_fault, 1);
    check("t3_next_unit", bus.unitlist, 1);
    wait_idle(40);

    // 4: illegal reports
    check("t4_bad_before", bus.bad_event, 0);
    ev(2'd3, 2'd1, 1'b0);
    check("t4_bad_unit", bus.bad_event, 1);
    check("t4_count_a", bus.count, 0);
    ev(2'd0, 2'd0, 1'b0);
    check("t4_count_b", bus.count, 0);
    check("t4_bad_sticky", bus.bad_event, 1);
    repeat (4) tick();
    check("t4_no_display", flags(), 0);
    check("t4_idle", bus.busy, 0);

    // 5: simultaneous push/pop at count 2, after pointer wrap
    ev(2'd0, 2'd2, 1'b1);
    check("t5_c1", bus.count, 1);
    ev(2'd1, 2'd3, 1'b1);
    check("t5_c1b", bus.count, 1);
    check("t5_x_shown", bus.p_block, 1);
    ev(2'd2, 2'd1, 1'b1);
    check("t5_c2", bus.count, 2);
    repeat (10) tick();
    check("t5_pre_count", bus.count, 2);
    check("t5_pre_flags", flags(), 0);
    check("t5_pre_busy", bus.busy, 1);
    ev(2'd0, 2'd3, 1'b1);
    check("t5_pushpop", bus.count, 2);
    check("t5_y_shown", bus.b_drop, 1);
    check("t5_y_unit", bus.unitlist, 1);
    wait_idle(60);
    check("t5_drained", exp_q.size(), 0);

    // 6: async reset mid-SHOW with 3 queued
    ev(2'd1, 2'd1, 1'b1);
    ev(2'd2, 2'd2, 1'b1);
    ev(2'd0, 2'd3, 1'b1);
    ev(2'd1, 2'd2, 1'b1);
    check("t6_queued", bus.count, 3);
    check("t6_shown", bus.i_fault, 1);
    tick();
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("t6_flags", flags(), 0);
    check("t6_unit", bus.unitlist, 0);
    check("t6_count", bus.count, 0);
    check("t6_ovf", bus.overflow, 0);
    check("t6_bad", bus.bad_event, 0);
    check("t6_busy", bus.busy, 0);
    check("t6_ready", bus.ev_ready, 1);
    repeat (2) tick();
    reset = 1'b0;
    repeat (30) tick();
    check("t6_quiet_flags", flags(), 0);
    check("t6_quiet_busy", bus.busy, 0);
    ev(2'd2, 2'd2, 1'b1);
    tick();
    check("t6_new_show", bus.p_block, 1);
    check("t6_new_unit", bus.unitlist, 2);
    wait_idle(30);
    check("t6_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end
endmodule

// File: doc/fault_event_queue.md
# fault_event_queue

Buffers fault reports from the bot's unit-inspection logic and presents them one at a time to the LED driver stage downstream as a unit index plus one-hot fault flags. Each fault is shown for a fixed hold time, or until the bot reports the fault resolved. A blank gap follows each fault so consecutive identical faults remain visually distinct. The block runs on the 50 MHz system clock and directly drives the `unitlist`, `i_fault`, `p_block` and `b_drop` inputs of the LED stage.

## Interface
- `DEPTH`, 4: queue entries; power of two, at least 2.
- `HOLD_CYCLES`, 50_000_000: cycles each fault is displayed (1 s at 50 MHz); at least 1.
- `GAP_CYCLES`, 5_000_000: cycles with all flags low between faults; at least 1.

Ports:
- `clk_50M` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `ev_valid` in 1: fault report strobe.
- `ev_unit` in 2: unit index; 0..2 valid, 3 illegal.
- `ev_type` in 2: 1 = i_fault, 2 = p_block, 3 = b_drop, 0 = illegal.
- `ev_ready` out 1: queue not full.
- `resolve` in 1: single-cycle pulse; the currently displayed fault is fixed.
- `unitlist` out 2: unit index of the displayed fault.
- `i_fault`, `p_block`, `b_drop` out 1 each: one-hot fault type; all low when nothing is displayed.
- `busy` out 1: high unless the block is in IDLE with an empty queue.
- `count` out $clog2(DEPTH)+1: current queue occupancy.
- `overflow` out 1: sticky; a report arrived while the queue was full.
- `bad_event` out 1: sticky; an illegal report arrived.

## Operation
- All outputs are registered.
- Reset values: all flags 0, `unitlist` 0, `count` 0, `overflow` 0, `bad_event` 0, `busy` 0, `ev_ready` 1, state IDLE. Any queued content is discarded.
- **Accept rule:** a report is pushed when `ev_valid & ev_ready` and it is legal.
  - An illegal report (`ev_unit==3` or `ev_type==0`) is dropped and sets `bad_event`.
  - `ev_valid & ~ev_ready` drops the report and sets `overflow`.
  - Sticky flags clear only on reset.
- `ev_ready = (count != DEPTH)`, taken from registered state.
- A push and a pop in the same cycle are both performed and `count` is unchanged. Pointers wrap modulo DEPTH.
- **IDLE:** if `count != 0`, pop the head, load `unitlist` and the flag matching its type, load the timer with HOLD_CYCLES-1, and go to SHOW.
- **SHOW:** the timer decrements each cycle. On timer==0 or `resolve`, clear all flags, load the timer with GAP_CYCLES-1, and go to GAP. `unitlist` holds its value.
- **GAP:** the timer decrements. On timer==0, go to IDLE. `resolve` is ignored in GAP and IDLE.
- Flags are never more than one-hot.
- The timer width is $clog2(max(HOLD_CYCLES, GAP_CYCLES)). The timer does not wrap below 0.

## Timing
- A report sampled at edge N with the queue empty and the block in IDLE gives `count=1` after N and flags valid after edge N+1.
- The fault stays displayed for exactly HOLD_CYCLES cycles when `resolve` is not asserted.
- `resolve` sampled at edge M while in SHOW gives flags low after M. The next fault appears GAP_CYCLES+1 cycles later if one is queued.
- `resolve` in the same cycle as timeout has a single effect: go to GAP.
- Asynchronous reset mid-SHOW drops all flags immediately, without waiting for a clock edge.

## Structure
- Shared package holds:
  - fault-type encodings: FT_NONE=0, FT_IFAULT=1, FT_PBLOCK=2, FT_BDROP=3;
  - the state enum {IDLE, SHOW, GAP};
  - MAX_UNIT=2.
- One sub-module, `fault_fifo`, a synchronous FIFO with parameter DEPTH, width 4 bits ({unit, type}), and `count`/full/empty outputs.
- The top level contains the FSM, the timer, and the sticky flags.

## Test plan
Benches use small parameters: HOLD_CYCLES=8, GAP_CYCLES=3, DEPTH=4.
1. Reset, then a single report unit=1 type=2 → `p_block=1`, `unitlist=1` two edges later, held 8 cycles, then 3 low cycles, then IDLE with `busy=0`.
2. Five back-to-back reports while the first is displayed → 4 reports accepted; the 5th is refused with `ev_ready=0` and `overflow=1`; the four are displayed in FIFO order.
3. `resolve` on the 3rd SHOW cycle → flags low next edge; the next fault starts after 3 gap cycles; `resolve` during GAP has no effect.
4. Illegal reports (unit=3 type=1; unit=0 type=0) → not queued, `count` unchanged, `bad_event=1`.
5. Push and pop in the same cycle with count=2 → count stays 2; after wrap-around the ordering is preserved.
6. Reset asserted mid-SHOW with 3 queued → flags, `count` and sticky bits go to 0 without a clock edge; after release there is no display until a new report arrives.
